// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic_controller lamp bus: decodes phase, checks sequence and dwell.
// Optional upper dwell limit enabled by defining TLM_TIMEOUT_EN.
module traffic_light_monitor #(
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_DWELL  = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [3:0]       lamp,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic             valid,
    output logic [CNT_W-1:0] dwell,
    output logic [7:0]       cycles,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
    localparam logic [1:0]       CODE_ENC   = 2'b01;
    localparam logic [1:0]       CODE_TRANS = 2'b10;
    localparam logic [1:0]       CODE_DWELL = 2'b11;

    // The timeout compare needs MAX_DWELL+1 to be reachable before saturation.
    if (64'(MAX_DWELL) >= (64'(1) << CNT_W)) begin : g_bad_cfg
        $error("traffic_light_monitor: MAX_DWELL must be below 2**CNT_W");
    end

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       cycles_q, cycles_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic             lamp_oh;
    logic [3:0]       succ;
    logic             short_dwell;
    logic             viol;
    logic [1:0]       viol_code;
    logic [1:0]       lamp_phase;

    assign lamp_oh = $onehot(lamp);
    // Legal order NSG->NSY->EWG->EWY->NSG is a left rotate of the one-hot lamp.
    assign succ    = {prev_q[2:0], prev_q[3]};
    assign short_dwell = ((prev_q[0] | prev_q[2]) && (dwell_q < MIN_G_C)) ||
                         ((prev_q[1] | prev_q[3]) && (dwell_q < MIN_Y_C));

    always_comb begin
        lamp_phase = 2'd0;
        unique case (lamp)
            4'b0010: lamp_phase = 2'd1;
            4'b0100: lamp_phase = 2'd2;
            4'b1000: lamp_phase = 2'd3;
            default: lamp_phase = 2'd0;
        endcase
    end

    // Next-state, sequence and dwell checks.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        dwell_d   = dwell_q;
        phase_d   = phase_q;
        cycles_d  = cycles_q;
        viol      = 1'b0;
        viol_code = 2'b00;

        if (en) begin
            prev_d = lamp;
            if (lamp == prev_q) begin
                dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);
            end else begin
                dwell_d = CNT_W'(1);
            end
            if (lamp_oh) begin
                phase_d = lamp_phase;
            end

            if ((lamp != 4'b0000) && !lamp_oh) begin
                viol      = 1'b1;
                viol_code = CODE_ENC;
                state_d   = SYNC;
            end else if (state_q == SYNC) begin
                if (lamp_oh) begin
                    state_d = TRACK;
                end
            end else if (lamp == 4'b0000) begin
                state_d = SYNC;
            end else if (lamp != prev_q) begin
                if (lamp != succ) begin
                    viol      = 1'b1;
                    viol_code = CODE_TRANS;
                end else if (short_dwell) begin
                    viol      = 1'b1;
                    viol_code = CODE_DWELL;
                end
                if ((lamp == succ) && (prev_q == 4'b1000)) begin
                    cycles_d = cycles_q + 8'd1;
                end
            end
`ifdef TLM_TIMEOUT_EN
            else if (dwell_q == CNT_W'(MAX_DWELL)) begin
                viol      = 1'b1;
                viol_code = CODE_DWELL;
            end
`endif
        end
    end

    // Sticky fault: first cause wins; a violation on a clear edge overrides the clear.
    always_comb begin
        fault_d = fault_q & ~clr_fault;
        code_d  = clr_fault ? 2'b00 : code_q;
        if (viol) begin
            fault_d = 1'b1;
            if (!fault_q || clr_fault) begin
                code_d = viol_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= SYNC;
            prev_q   <= 4'b0000;
            dwell_q  <= '0;
            phase_q  <= 2'd0;
            cycles_q <= 8'd0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            dwell_q  <= dwell_d;
            phase_q  <= phase_d;
            cycles_q <= cycles_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end

    assign phase      = phase_q;
    assign valid      = (state_q == TRACK);
    assign dwell      = dwell_q;
    assign cycles     = cycles_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with MIN_GREEN=4, MIN_YELLOW=2, MAX_DWELL=16.
module tb_traffic_light_monitor;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             res;
    logic             en;
    logic [3:0]       lamp;
    logic             clr_fault;
    logic [1:0]       phase;
    logic             valid;
    logic [CNT_W-1:0] dwell;
    logic [7:0]       cycles;
    logic             fault;
    logic [1:0]       fault_code;

    int checks = 0;
    int errors = 0;

    traffic_light_monitor #(
        .MIN_GREEN (4),
        .MIN_YELLOW(2),
        .MAX_DWELL (16),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .res       (res),
        .en        (en),
        .lamp      (lamp),
        .clr_fault (clr_fault),
        .phase     (phase),
        .valid     (valid),
        .dwell     (dwell),
        .cycles    (cycles),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] l);
        lamp = l;
        tick();
    endtask

    task automatic run(input logic [3:0] l, input int n);
        for (int i = 0; i < n; i++) sample(l);
    endtask

    task automatic do_reset();
        res  = 1'b1;
        lamp = 4'b0000;
        tick();
        res  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_phase"},  32'(phase), 0);
        check({tag, "_valid"},  32'(valid), 0);
        check({tag, "_dwell"},  32'(dwell), 0);
        check({tag, "_cycles"}, 32'(cycles), 0);
        check({tag, "_fault"},  32'(fault), 0);
        check({tag, "_code"},   32'(fault_code), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res       = 1'b1;
        en        = 1'b1;
        lamp      = 4'b0000;
        clr_fault = 1'b0;
        do_reset();
        check_reset_vals("rst");

        // Two legal cycles, then the closing NSG completes the second.
        sample(4'b0001);
        check("legal_valid_first", 32'(valid), 1);
        check("legal_dwell_first", 32'(dwell), 1);
        run(4'b0001, 3);
        run(4'b0010, 2);
        run(4'b0100, 4);
        run(4'b1000, 2);
        check("legal_phase_ewy", 32'(phase), 3);
        check("legal_dwell_ewy", 32'(dwell), 2);
        run(4'b0001, 4);
        run(4'b0010, 2);
        run(4'b0100, 4);
        run(4'b1000, 2);
        check("legal_cycles_mid", 32'(cycles), 1);
        check("legal_fault_mid", 32'(fault), 0);
        sample(4'b0001);
        check("legal_cycles", 32'(cycles), 2);
        check("legal_fault", 32'(fault), 0);
        check("legal_valid", 32'(valid), 1);

        // Short green.
        do_reset();
        run(4'b0001, 3);
        check("short_fault_pre", 32'(fault), 0);
        sample(4'b0010);
        check("short_fault", 32'(fault), 1);
        check("short_code", 32'(fault_code), 3);

        // Illegal transition, first cause wins, clear racing a new violation.
        do_reset();
        run(4'b0001, 4);
        sample(4'b0100);
        check("trans_fault", 32'(fault), 1);
        check("trans_code", 32'(fault_code), 2);
        check("trans_valid", 32'(valid), 1);
        check("trans_phase", 32'(phase), 2);
        sample(4'b0110);
        check("enc_keep_code", 32'(fault_code), 2);
        check("enc_valid", 32'(valid), 0);
        clr_fault = 1'b1;
        sample(4'b0110);
        clr_fault = 1'b0;
        check("clr_race_fault", 32'(fault), 1);
        check("clr_race_code", 32'(fault_code), 1);
        en        = 1'b0;
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        en        = 1'b1;
        check("clr_noen_fault", 32'(fault), 0);
        check("clr_noen_code", 32'(fault_code), 0);

        // Dark resync.
        do_reset();
        run(4'b0001, 4);
        sample(4'b0000);
        check("dark_valid", 32'(valid), 0);
        run(4'b0000, 2);
        run(4'b1000, 2);
        check("dark_valid_relock", 32'(valid), 1);
        check("dark_phase", 32'(phase), 3);
        check("dark_fault", 32'(fault), 0);
        check("dark_dwell", 32'(dwell), 2);

        // Enable freeze, then reset over en=0 and clr_fault.
        do_reset();
        run(4'b0001, 4);
        sample(4'b0010);
        check("en_dwell_pre", 32'(dwell), 1);
        en   = 1'b0;
        lamp = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        check("en_dwell_hold", 32'(dwell), 1);
        check("en_phase_hold", 32'(phase), 1);
        check("en_fault_hold", 32'(fault), 0);
        en = 1'b1;
        sample(4'b1000);
        check("en_after_fault", 32'(fault), 1);
        check("en_after_code", 32'(fault_code), 2);
        en        = 1'b0;
        clr_fault = 1'b1;
        res       = 1'b1;
        tick();
        res       = 1'b0;
        clr_fault = 1'b0;
        en        = 1'b1;
        check_reset_vals("midrst");

        // Stuck phase.
        do_reset();
        run(4'b0100, 16);
        check("to_fault_16", 32'(fault), 0);
        check("to_dwell_16", 32'(dwell), 16);
        sample(4'b0100);
        check("to_dwell_17", 32'(dwell), 17);
`ifdef TLM_TIMEOUT_EN
        check("to_fault_17", 32'(fault), 1);
        check("to_code_17", 32'(fault_code), 3);
`else
        check("to_fault_17", 32'(fault), 0);
        check("to_code_17", 32'(fault_code), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
